// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: clips the drawer's pixel stream to the framebuffer, turns
// (x,y) into a linear address and writes colour to memory through a small FIFO
// that rides out memory stalls.
// Optional feature: define FB_PIXEL_WRITER_CLIPSTAT_EN to add a saturating
// clip_count output that counts discarded (off-screen) pixels.
module fb_pixel_writer #(
  parameter int CORDW      = 10,
  parameter int COLRW      = 4,
  parameter int FB_WIDTH   = 320,
  parameter int FB_HEIGHT  = 180,
  parameter int ADDRW      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             px_valid,
  input  logic [CORDW-1:0] px_x,
  input  logic [CORDW-1:0] px_y,
  input  logic [COLRW-1:0] px_colr,
  output logic             px_ready,
  input  logic             mem_busy,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [COLRW-1:0] mem_data,
  output logic             busy
`ifdef FB_PIXEL_WRITER_CLIPSTAT_EN
  ,
  output logic [15:0]      clip_count
`endif
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int ENTW = ADDRW + COLRW;
  localparam logic [31:0] FBW_C = 32'(FB_WIDTH);
  localparam logic [31:0] FBH_C = 32'(FB_HEIGHT);

  logic             accept_s;
  logic             clip_s;
  logic [ADDRW-1:0] addr_s;
  logic             push_s;
  logic             pop_s;

  logic             s1_valid_r;
  logic             s1_clip_r;
  logic [ADDRW-1:0] s1_addr_r;
  logic [COLRW-1:0] s1_colr_r;

  logic [ENTW-1:0]  fifo_mem_r [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_ptr_r;
  logic [PTRW-1:0]  rd_ptr_r;
  logic [CNTW-1:0]  count_r;

  // Accept decision, clip test and address arithmetic on the incoming pixel.
  always_comb begin
    accept_s = px_valid && px_ready;
    clip_s   = (32'(px_x) >= FBW_C) || (32'(px_y) >= FBH_C);
    addr_s   = ADDRW'(px_y) * ADDRW'(FB_WIDTH) + ADDRW'(px_x);
  end

  // Only unclipped S1 results enter the FIFO; head leaves whenever memory can take it.
  always_comb begin
    push_s = s1_valid_r && !s1_clip_r;
    pop_s  = (count_r != CNTW'(0)) && !mem_busy;
  end

  // Ready depends on registered occupancy only; S1 reserves a slot even if it will be clipped.
  always_comb begin
    px_ready = !rst && ((count_r + CNTW'(s1_valid_r)) < CNTW'(FIFO_DEPTH));
    busy     = s1_valid_r | (count_r != CNTW'(0)) | mem_we;
  end

  // Stage S1: register the clip verdict, linear address and colour of an accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_clip_r  <= 1'b0;
      s1_addr_r  <= '0;
      s1_colr_r  <= '0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_clip_r <= clip_s;
        s1_addr_r <= addr_s;
        s1_colr_r <= px_colr;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {s1_addr_r, s1_colr_r};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTRW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTRW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Memory write port: one strobe per popped entry, address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= pop_s;
      if (pop_s) begin
        {mem_addr, mem_data} <= fifo_mem_r[rd_ptr_r];
      end
    end
  end

`ifdef FB_PIXEL_WRITER_CLIPSTAT_EN
  // Saturating count of pixels discarded by the clip test.
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_count <= 16'h0000;
    end else if (s1_valid_r && s1_clip_r && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'h0001;
    end else begin
      clip_count <= clip_count;
    end
  end
`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Testbench for fb_pixel_writer: directed scenarios with randomized pixel data,
// checked against a queue-based reference of expected framebuffer writes.
module tb_fb_pixel_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        px_valid = 1'b0;
  logic [9:0]  px_x = 10'd0;
  logic [9:0]  px_y = 10'd0;
  logic [3:0]  px_colr = 4'd0;
  logic        px_ready;
  logic        mem_busy = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [3:0]  mem_data;
  logic        busy;
`ifdef FB_PIXEL_WRITER_CLIPSTAT_EN
  logic [15:0] clip_count;
`endif

  fb_pixel_writer dut (
    .clk(clk), .rst(rst), .px_valid(px_valid), .px_x(px_x), .px_y(px_y),
    .px_colr(px_colr), .px_ready(px_ready), .mem_busy(mem_busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
`ifdef FB_PIXEL_WRITER_CLIPSTAT_EN
    , .clip_count(clip_count)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int writes = 0;
  logic [19:0] exp_q[$];          // {addr, colr} of every write still owed
  logic        acc;
  logic        s_we, s_ready, s_busy;
  logic [15:0] s_addr;
  logic [3:0]  s_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock cycle: apply inputs, decide acceptance and snapshot outputs at negedge.
  task automatic drive(input logic v, input int x, input int y, input int c, input logic mb);
    px_valid = v; px_x = 10'(x); px_y = 10'(y); px_colr = 4'(c); mem_busy = mb;
    @(negedge clk);
    acc = v && px_ready;
    if (acc && x < 320 && y < 180)
      exp_q.push_back({16'(y * 320 + x), 4'(c)});
    s_we = mem_we; s_ready = px_ready; s_busy = busy; s_addr = mem_addr; s_data = mem_data;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      drive(1'b0, 0, 0, 0, 1'b0);
      n++;
    end
    check("drain_done", 32'(busy), 32'd0);
  endtask

  // Write monitor: every strobe must match the oldest owed write, in order.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      writes++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL unexpected_write: observed addr %0d expected no write", mem_addr);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        assert ({mem_addr, mem_data} === e) else begin
          fails++;
          $error("FAIL write_order: observed addr %0d data %0d expected addr %0d data %0d",
                 mem_addr, mem_data, e[19:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    int w0, nw, idx, n;
    int xs[8], ys[8], cs[8];

    // Reset state
    drive(1'b0, 0, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_we", 32'(s_we), 32'd0);
    check("rst_addr", 32'(s_addr), 32'd0);
    check("rst_data", 32'(s_data), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    check("ready_after_rst", 32'(s_ready), 32'd1);

    // 1: single pixel latency
    drive(1'b1, 5, 2, 3, 1'b0);
    check("t1_accept", 32'(acc), 32'd1);
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t1_we_n1", 32'(s_we), 32'd0);
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t1_we_n2", 32'(s_we), 32'd0);
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t1_we_n3", 32'(s_we), 32'd1);
    check("t1_addr", 32'(s_addr), 32'd645);
    check("t1_data", 32'(s_data), 32'd3);
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t1_we_n4", 32'(s_we), 32'd0);
    check("t1_busy_n4", 32'(s_busy), 32'd0);
    check("t1_addr_hold", 32'(s_addr), 32'd645);

    // 2: corner and clipped pixels
    w0 = writes;
    drive(1'b1, 319, 179, 15, 1'b0);
    drive(1'b1, 320, 0, 1, 1'b0);
    drive(1'b1, 0, 180, 2, 1'b0);
    drain();
    check("t2_writes", 32'(writes - w0), 32'd1);
    check("t2_corner_addr", 32'(mem_addr), 32'd57599);
    check("t2_corner_data", 32'(mem_data), 32'd15);
`ifdef FB_PIXEL_WRITER_CLIPSTAT_EN
    check("t2_clip_count", 32'(clip_count), 32'd2);
`endif

    // 3: stalled memory, px_valid held: only FIFO_DEPTH pixels get in
    for (int i = 0; i < 8; i++) begin
      xs[i] = 10 + 20 * i + $urandom_range(0, 19);
      ys[i] = $urandom_range(0, 179);
      cs[i] = $urandom_range(0, 15);
    end
    w0 = writes; idx = 0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, xs[idx], ys[idx], cs[idx], 1'b1);
      if (acc) idx++;
    end
    check("t3_accepted_stalled", 32'(idx), 32'd4);
    check("t3_ready_full", 32'(s_ready), 32'd0);
    n = 0;
    while (idx < 8 && n < 40) begin
      drive(1'b1, xs[idx], ys[idx], cs[idx], 1'b0);
      if (acc) idx++;
      n++;
    end
    check("t3_all_accepted", 32'(idx), 32'd8);
    drain();
    check("t3_writes", 32'(writes - w0), 32'd8);

    // 4: continuous stream at full rate
    nw = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, $urandom_range(0, 319), $urandom_range(0, 179), $urandom_range(0, 15), 1'b0);
      check("t4_ready", 32'(s_ready), 32'd1);
      nw += int'(s_we);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 0, 0, 1'b0);
      nw += int'(s_we);
    end
    check("t4_consecutive_writes", 32'(nw), 32'd16);
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t4_we_after", 32'(s_we), 32'd0);

    // 5: full occupancy, one pop cycle while S1 pushes
    w0 = writes; idx = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom_range(0, 319), $urandom_range(0, 179), $urandom_range(0, 15), 1'b1);
      if (acc) idx++;
    end
    check("t5_filled", 32'(idx), 32'd4);
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t5_ready_full", 32'(s_ready), 32'd0);
    drive(1'b0, 0, 0, 0, 1'b1);
    check("t5_single_we", 32'(s_we), 32'd1);
    check("t5_ready_after_pop", 32'(s_ready), 32'd1);
    drive(1'b0, 0, 0, 0, 1'b1);
    check("t5_we_stalled", 32'(s_we), 32'd0);
    check("t5_busy_stalled", 32'(s_busy), 32'd1);
    drain();
    check("t5_writes", 32'(writes - w0), 32'd4);

    // 6: reset mid-stream drops everything in flight
    w0 = writes;
    for (int i = 0; i < 3; i++)
      drive(1'b1, $urandom_range(0, 319), $urandom_range(0, 179), $urandom_range(0, 15), 1'b0);
    rst = 1'b1;
    exp_q.delete();
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t6_ready_in_rst", 32'(s_ready), 32'd0);
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 1'b0);
    check("t6_we_after_rst", 32'(s_we), 32'd0);
    check("t6_busy_after_rst", 32'(s_busy), 32'd0);
    nw = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 0, 0, 0, 1'b0);
      nw += int'(s_we);
    end
    check("t6_no_stale_write", 32'(nw), 32'd0);
    check("t6_monitor_writes", 32'(writes - w0), 32'd0);
`ifdef FB_PIXEL_WRITER_CLIPSTAT_EN
    check("t6_clip_cleared", 32'(clip_count), 32'd0);
`endif

    check("owed_writes_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
